win5x5_gen: RTL and testbench

Streaming 5x5 sliding-window generator that sits directly upstream of the 5x5 edge/blur kernels. It accepts one 8-bit raster-order pixel per valid cycle and buffers the four previous image rows internally. It emits a packed 200-bit window whenever the window lies fully inside the image, in the exact bit layout the downstream kernel consumes. Border windows are never emitted, so each frame yields (IMG_WIDTH-4)*(IMG_HEIGHT-4) windows.

---
 rtl/win_pkg.sv | 19 +
 rtl/line_buf_4row.sv | 24 ++
 rtl/win5x5_gen.sv | 135 +++++++++++++
 tb/tb_win5x5_gen.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/win_pkg.sv
// Shared constants, FSM state type and window bit-layout helper for the
// 5x5 sliding-window generator.
package win_pkg;

    localparam int PIX_W    = 8;
    localparam int WIN_K    = 5;
    localparam int WIN_BITS = PIX_W * WIN_K * WIN_K;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    // LSB offset of window pixel (row r, col c) in the packed 200-bit bus.
    function automatic int unsigned bit_off(input int unsigned r, input int unsigned c);
        return (PIX_W * WIN_K * r) + (PIX_W * c);
    endfunction

endpackage

// File: rtl/line_buf_4row.sv
// Four-row line buffer: one 32-bit word per column holding rows y-4..y-1.
// Combinational read, synchronous read-before-write at the same address.
module line_buf_4row #(
    parameter int DEPTH = 64
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [31:0]              wdata,
    output logic [31:0]              rdata
);

    // No reset on the array so it maps onto distributed RAM.
    logic [31:0] mem [DEPTH];

    assign rdata = mem[addr];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

endmodule

// File: rtl/win5x5_gen.sv
// Streaming 5x5 window generator: frame FSM, raster counters, window array
// and registered window/strobe outputs. Border windows are suppressed.
module win5x5_gen
    import win_pkg::*;
#(
    parameter int IMG_WIDTH  = 64,
    parameter int IMG_HEIGHT = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [PIX_W-1:0]    pix_in,
    input  logic                pix_valid,
    input  logic                sof,
    output logic [WIN_BITS-1:0] win_out,
    output logic                win_valid,
    output logic                frame_done,
    output logic                busy,
    output logic                state_dbg
);

    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);

    state_t state, state_nxt;

    logic [CW-1:0] col, pos_col;
    logic [RW-1:0] row, pos_row;
    logic          accept, last_pix, emit;

    logic [31:0]      lb_rd;
    logic [PIX_W-1:0] win     [WIN_K][WIN_K];
    logic [PIX_W-1:0] win_nxt [WIN_K][WIN_K];
    logic [WIN_BITS-1:0] win_pack;

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)   state_nxt = ACTIVE;
            ACTIVE:  if (last_pix) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs; sof relocates the current pixel to (0,0) in either state.
    always_comb begin
        accept    = pix_valid && ((state == ACTIVE) || sof);
        pos_col   = sof ? '0 : col;
        pos_row   = sof ? '0 : row;
        last_pix  = accept && (pos_col == CW'(IMG_WIDTH - 1))
                           && (pos_row == RW'(IMG_HEIGHT - 1));
        emit      = accept && (pos_col >= CW'(WIN_K - 1))
                           && (pos_row >= RW'(WIN_K - 1));
        busy      = rst_n && ((state == ACTIVE) || (pix_valid && sof));
        state_dbg = state;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col <= '0;
            row <= '0;
        end else if (accept) begin
            if (pos_col == CW'(IMG_WIDTH - 1)) begin
                col <= '0;
                row <= (pos_row == RW'(IMG_HEIGHT - 1)) ? '0 : pos_row + RW'(1);
            end else begin
                col <= pos_col + CW'(1);
                row <= pos_row;
            end
        end
    end

    line_buf_4row #(
        .DEPTH (IMG_WIDTH)
    ) u_line_buf (
        .clk   (clk),
        .we    (accept),
        .addr  (pos_col),
        .wdata ({lb_rd[23:0], pix_in}),
        .rdata (lb_rd)
    );

    // Shift every row left; the new right column is the buffered column plus pix_in.
    always_comb begin
        for (int r = 0; r < WIN_K; r++) begin
            for (int c = 0; c < WIN_K - 1; c++) begin
                win_nxt[r][c] = win[r][c+1];
            end
        end
        win_nxt[0][4] = lb_rd[31:24];
        win_nxt[1][4] = lb_rd[23:16];
        win_nxt[2][4] = lb_rd[15:8];
        win_nxt[3][4] = lb_rd[7:0];
        win_nxt[4][4] = pix_in;
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            win <= win_nxt;
        end
    end

    always_comb begin
        win_pack = '0;
        for (int r = 0; r < WIN_K; r++) begin
            for (int c = 0; c < WIN_K; c++) begin
                win_pack[bit_off(r, c) +: PIX_W] = win_nxt[r][c];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_out    <= '0;
            win_valid  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            win_valid  <= emit;
            frame_done <= last_pix;
            if (emit) begin
                win_out <= win_pack;
            end
        end
    end

endmodule

// File: tb/tb_win5x5_gen.sv
// Bench for win5x5_gen on an 8x6 image: image-array reference model,
// expected-window queue, directed phases with randomized gaps and pixels.
module tb_win5x5_gen;

    localparam int W = 8;
    localparam int H = 6;

    logic         clk;
    logic         rst_n;
    logic [7:0]   pix_in;
    logic         pix_valid;
    logic         sof;
    logic [199:0] win_out;
    logic         win_valid;
    logic         frame_done;
    logic         busy;
    logic         state_dbg;

    win5x5_gen #(
        .IMG_WIDTH  (W),
        .IMG_HEIGHT (H)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pix_in     (pix_in),
        .pix_valid  (pix_valid),
        .sof        (sof),
        .win_out    (win_out),
        .win_valid  (win_valid),
        .frame_done (frame_done),
        .busy       (busy),
        .state_dbg  (state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model state
    logic [7:0]   img [H][W];
    logic [199:0] exp_q[$];
    logic [199:0] last_win;
    logic [199:0] first_seen, last_seen;
    bit           m_active;
    int           m_col, m_row;
    int           n_vec, miscompares;
    int           wins_seen, fd_seen;

    task automatic chk(input string tag, input logic [199:0] obs, input logic [199:0] expv);
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        m_active = 1'b0;
        m_col    = 0;
        m_row    = 0;
        last_win = '0;
        exp_q.delete();
    endtask

    // One input cycle: drive, predict, check busy, then check registered outputs.
    task automatic step(input logic v, input logic s, input logic [7:0] p);
        logic         acc, exp_fd, exp_busy, exp_valid;
        logic [199:0] w;
        int           x, y;
        pix_valid = v;
        sof       = s;
        pix_in    = p;
        acc       = v && (m_active || s);
        exp_busy  = m_active || (v && s);
        exp_fd    = 1'b0;
        if (acc) begin
            if (s) begin
                m_col = 0;
                m_row = 0;
            end
            x = m_col;
            y = m_row;
            img[y][x] = p;
            if (x >= 4 && y >= 4) begin
                w = '0;
                for (int r = 0; r < 5; r++)
                    for (int c = 0; c < 5; c++)
                        w[40*r + 8*c +: 8] = img[y-4+r][x-4+c];
                exp_q.push_back(w);
            end
            if (x == W-1 && y == H-1) begin
                exp_fd   = 1'b1;
                m_active = 1'b0;
                m_col    = 0;
                m_row    = 0;
            end else begin
                m_active = 1'b1;
                m_col    = x + 1;
                m_row    = y;
                if (m_col == W) begin
                    m_col = 0;
                    m_row = y + 1;
                end
            end
        end
        #1;
        n_vec++;
        chk("busy", busy, exp_busy);
        @(posedge clk);
        #1;
        exp_valid = (exp_q.size() > 0);
        chk("win_valid", win_valid, exp_valid);
        if (win_valid && exp_valid) begin
            last_win = exp_q.pop_front();
            if (wins_seen == 0) first_seen = win_out;
            last_seen = win_out;
        end
        if (win_valid) wins_seen++;
        chk("win_out", win_out, last_win);
        chk("frame_done", frame_done, exp_fd);
        if (frame_done) fd_seen++;
    endtask

    task automatic gap_cycles(input bit enable);
        int n;
        n = 0;
        while (enable && n < 3 && $urandom_range(1, 0) == 1) begin
            step(1'b0, 1'($urandom_range(1, 0)), 8'($urandom));
            n++;
        end
    endtask

    // Feed a frame from (0,0); pixel = base + 16*y + x, or random when rnd is set.
    task automatic send_frame(input logic [7:0] base, input bit gaps, input bit rnd,
                              input int stop_x, input int stop_y);
        logic [7:0] p;
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                if (y > stop_y || (y == stop_y && x > stop_x)) return;
                gap_cycles(gaps);
                p = rnd ? 8'($urandom) : 8'(base + 16*y + x);
                step(1'b1, (x == 0 && y == 0), p);
            end
        end
    endtask

    initial begin
        n_vec = 0; miscompares = 0; wins_seen = 0; fd_seen = 0;
        first_seen = '0; last_seen = '0;
        rst_n = 1'b0; pix_valid = 1'b0; sof = 1'b0; pix_in = '0;
        model_reset();

        // reset held with random inputs
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            pix_valid = 1'($urandom_range(1, 0));
            sof       = 1'($urandom_range(1, 0));
            pix_in    = 8'($urandom);
            #2;
            n_vec++;
            chk("rst_win_out", win_out, '0);
            chk("rst_valid", {win_valid, frame_done, busy, state_dbg}, '0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;

        // valid pixels without sof are dropped
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'($urandom));
        chk("idle_wins", wins_seen, 0);

        // clean contiguous frame
        wins_seen = 0; fd_seen = 0;
        send_frame(8'h00, 1'b0, 1'b0, W, H);
        chk("f1_count", wins_seen, 8);
        chk("f1_fd", fd_seen, 1);
        chk("f1_first_00", first_seen[7:0], 8'h00);
        chk("f1_first_04", first_seen[39:32], 8'h04);
        chk("f1_first_40", first_seen[167:160], 8'h40);
        chk("f1_first_44", first_seen[199:192], 8'h44);
        chk("f1_last_57", last_seen[199:192], 8'h57);

        // same frame with random gaps
        step(1'b0, 1'b0, 8'h00);
        wins_seen = 0; fd_seen = 0;
        send_frame(8'h00, 1'b1, 1'b0, W, H);
        step(1'b0, 1'b0, 8'h00);
        chk("f2_count", wins_seen, 8);
        chk("f2_last_57", last_seen[199:192], 8'h57);

        // mid-frame restart at (3,2)
        wins_seen = 0; fd_seen = 0;
        send_frame(8'h00, 1'b0, 1'b0, 2, 2);
        send_frame(8'h80, 1'b0, 1'b0, W, H);
        chk("f3_count", wins_seen, 8);
        chk("f3_first_80", first_seen[7:0], 8'h80);
        chk("f3_last_d7", last_seen[199:192], 8'hd7);

        // back-to-back frames, sof right after the last pixel
        wins_seen = 0; fd_seen = 0;
        send_frame(8'h10, 1'b0, 1'b0, W, H);
        send_frame(8'h20, 1'b0, 1'b0, W, H);
        step(1'b0, 1'b0, 8'h00);
        chk("b2b_count", wins_seen, 16);
        chk("b2b_fd", fd_seen, 2);

        // async reset during row 4, then a clean random frame
        send_frame(8'h00, 1'b1, 1'b1, 5, 4);
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++;
        chk("arst_win_out", win_out, '0);
        chk("arst_flags", {win_valid, frame_done, busy, state_dbg}, '0);
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        wins_seen = 0; fd_seen = 0;
        send_frame(8'h00, 1'b1, 1'b1, W, H);
        step(1'b0, 1'b0, 8'h00);
        chk("post_rst_count", wins_seen, 8);
        chk("post_rst_fd", fd_seen, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, miscompares);
        $finish;
    end

endmodule
